// File: rtl/wb_mtimer_pkg.sv
// Shared register offsets, CTRL bit positions, bus FSM states and byte-merge helper for the machine timer.
package wb_mtimer_pkg;

  localparam logic [2:0] MTIMER_OFS_MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIMER_OFS_MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMER_OFS_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMER_OFS_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MTIMER_OFS_CTRL        = 3'd4;
  localparam logic [2:0] MTIMER_OFS_PRESCALE    = 3'd5;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  localparam logic [63:0] MTIMER_CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [1:0]  MTIMER_CTRL_RESET = 2'b01;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_ERR  = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic [2:0]  ofs;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } bus_req_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_mtimer_if.sv
// Wishbone B4 classic data-bus signals between the core dbus master and the timer responder.
interface wb_mtimer_if;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb,
    input  wb_rdt, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb,
    output wb_rdt, wb_ack, wb_err
  );
endinterface

// File: rtl/mtimer_tick_gen.sv
// Prescaler: tick once per (prescale+1) enabled cycles; load restarts the count from the new value.
// Latency: tick is combinational from the counter; no handshake.
module mtimer_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] prescale,
  output logic        tick
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= prescale;
    end else if (en) begin
      cnt_q <= (cnt_q == 16'd0) ? prescale : cnt_q - 16'd1;
    end
  end

  assign tick = en & (cnt_q == 16'd0);

endmodule

// File: rtl/wb_mtimer.sv
// RISC-V machine timer on Wishbone B4 classic; 1-cycle registered ack/err, one idle cycle between accesses.
// Macro WB_MTIMER_PRESCALE_EN adds the PRESCALE register at offset 5 and the tick prescaler.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter logic [63:0] CMP_RESET  = MTIMER_CMP_RESET,
  parameter logic [1:0]  CTRL_RESET = MTIMER_CTRL_RESET
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  wb_mtimer_if.slave wb,
  output logic       irq
);

`ifdef WB_MTIMER_PRESCALE_EN
  localparam logic [2:0] MTIMER_OFS_LAST = MTIMER_OFS_PRESCALE;
`else
  localparam logic [2:0] MTIMER_OFS_LAST = MTIMER_OFS_CTRL;
`endif

  bus_state_e  state_q, state_d;
  bus_req_t    req_q;
  logic [2:0]  ofs;
  logic        req, accept, ofs_mapped, wr_en;
  logic [63:0] mtime_q, mtimecmp_q;
  logic [31:0] hi_shadow_q, rd_data, rdt_q;
  logic [1:0]  ctrl_q;
  logic        tick;
  logic        unused_adr;

  assign ofs        = wb.wb_adr[4:2];
  assign unused_adr = ^{wb.wb_adr[31:5], wb.wb_adr[1:0]};
  assign req        = wb.wb_cyc & wb.wb_stb & ~wb.wb_ack & ~wb.wb_err;
  assign accept     = req & (state_q == BUS_IDLE);
  assign ofs_mapped = (ofs <= MTIMER_OFS_LAST);
  // A master that drops cyc during the termination cycle abandons the write.
  assign wr_en      = (state_q == BUS_ACK) & req_q.we & wb.wb_cyc & wb.wb_stb;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= BUS_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = BUS_IDLE;
    case (state_q)
      BUS_IDLE: begin
        if (req) state_d = ofs_mapped ? BUS_ACK : BUS_ERR;
        else     state_d = BUS_IDLE;
      end
      default:   state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    wb.wb_ack = (state_q == BUS_ACK);
    wb.wb_err = (state_q == BUS_ERR);
    wb.wb_rdt = rdt_q;
  end

`ifdef WB_MTIMER_PRESCALE_EN
  logic [15:0] prescale_q, prescale_nxt;
  logic        prescale_wr;

  assign prescale_wr  = wr_en & (req_q.ofs == MTIMER_OFS_PRESCALE);
  assign prescale_nxt = {req_q.sel[1] ? req_q.dat[15:8] : prescale_q[15:8],
                         req_q.sel[0] ? req_q.dat[7:0]  : prescale_q[7:0]};

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)        prescale_q <= '0;
    else if (prescale_wr) prescale_q <= prescale_nxt;
  end

  mtimer_tick_gen u_tick_gen (
    .clk      (wb_clk),
    .rst_n    (wb_rst_n),
    .en       (ctrl_q[CTRL_EN_BIT]),
    .load     (prescale_wr),
    .prescale (prescale_nxt),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    rd_data = '0;
    case (ofs)
      MTIMER_OFS_MTIME_LO:    rd_data = mtime_q[31:0];
      MTIMER_OFS_MTIME_HI:    rd_data = hi_shadow_q;
      MTIMER_OFS_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
      MTIMER_OFS_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
      MTIMER_OFS_CTRL:        rd_data = {30'd0, ctrl_q};
`ifdef WB_MTIMER_PRESCALE_EN
      MTIMER_OFS_PRESCALE:    rd_data = {16'd0, prescale_q};
`endif
      default:                rd_data = '0;
    endcase
  end

  // Read data and the high-half shadow are sampled together so a LO/HI pair is coherent.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      req_q       <= '0;
      rdt_q       <= '0;
      hi_shadow_q <= '0;
    end else begin
      rdt_q <= accept ? rd_data : '0;
      if (accept) begin
        req_q.ofs <= ofs;
        req_q.we  <= wb.wb_we;
        req_q.dat <= wb.wb_dat;
        req_q.sel <= wb.wb_sel;
        if (!wb.wb_we && ofs == MTIMER_OFS_MTIME_LO) hi_shadow_q <= mtime_q[63:32];
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      mtime_q <= '0;
    end else if (wr_en && req_q.ofs == MTIMER_OFS_MTIME_LO) begin
      mtime_q[31:0]  <= merge_bytes(mtime_q[31:0], req_q.dat, req_q.sel);
    end else if (wr_en && req_q.ofs == MTIMER_OFS_MTIME_HI) begin
      mtime_q[63:32] <= merge_bytes(mtime_q[63:32], req_q.dat, req_q.sel);
    end else if (ctrl_q[CTRL_EN_BIT] && tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      mtimecmp_q <= CMP_RESET;
      ctrl_q     <= CTRL_RESET;
    end else if (wr_en) begin
      case (req_q.ofs)
        MTIMER_OFS_MTIMECMP_LO: mtimecmp_q[31:0]  <= merge_bytes(mtimecmp_q[31:0], req_q.dat, req_q.sel);
        MTIMER_OFS_MTIMECMP_HI: mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], req_q.dat, req_q.sel);
        MTIMER_OFS_CTRL:        if (req_q.sel[0]) ctrl_q <= req_q.dat[1:0];
        default:                ;
      endcase
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) irq <= 1'b0;
    else           irq <= ctrl_q[CTRL_IRQ_EN_BIT] & (mtime_q >= mtimecmp_q);
  end

endmodule
